// File: rtl/wb_req_encoder.sv
// wb_req_encoder: 8-to-3 write-back request encoder for the register file.
// Captures one-hot per-source write-back requests as pending, picks one
// (round-robin or fixed priority), and presents its 3-bit register index on a
// valid/ready handshake. Each accepted index is acknowledged with a one-cycle
// one-hot grant back to its source.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   en        in   enable for new selections (capture is unconditional)
//   req       in   [7:0] per-source request pulses
//   ready     in   write port accepts the presented address this cycle
//   ovf_clr   in   synchronous clear of all overflow flags
//   valid     out  addr is valid
//   addr      out  [2:0] selected register index
//   grant     out  [7:0] one-hot acknowledge, the cycle after acceptance
//   pending   out  [7:0] outstanding requests not yet accepted
//   overflow  out  [7:0] sticky per-source lost-request flags
//   busy      out  any request outstanding
module wb_req_encoder #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       ready,
  input  logic       ovf_clr,
  output logic       valid,
  output logic [2:0] addr,
  output logic [7:0] grant,
  output logic [7:0] pending,
  output logic [7:0] overflow,
  output logic       busy
);

  localparam int unsigned N_SRC = 8;
  localparam int unsigned AW    = 3;

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_last;
  logic [7:0]    r_grant;
  logic [7:0]    r_pending;
  logic [7:0]    r_overflow;
  logic          r_busy;

  logic          w_accept;
  logic [7:0]    w_acc_oh;
  logic [7:0]    w_pend_next;
  logic [7:0]    w_ovf_next;
  logic          w_sel;
  logic          w_found;
  logic [AW-1:0] w_win;
  logic [AW-1:0] w_idx;

  // Handshake and pending bookkeeping; a request for the index being accepted
  // this cycle is a fresh request, so it stays pending without overflowing.
  always_comb begin
    w_accept    = r_valid & ready;
    w_acc_oh    = w_accept ? (8'h01 << r_addr) : 8'h00;
    w_pend_next = (r_pending & ~w_acc_oh) | req;
    w_ovf_next  = (ovf_clr ? 8'h00 : r_overflow) | (req & r_pending & ~w_acc_oh);
    w_sel       = (~r_valid | w_accept) & en;
  end

  // Winner search over the next pending vector: rotating start after the last
  // winner for round-robin, index 0 first for fixed priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (RR_EN) w_idx = r_last + AW'(k + 1);
      else       w_idx = AW'(k);
      if (!w_found && w_pend_next[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Output/selection state; a presented address holds until accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_last     <= 3'b111;
      r_grant    <= 8'h00;
      r_pending  <= 8'h00;
      r_overflow <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      r_grant    <= w_acc_oh;
      r_pending  <= w_pend_next;
      r_overflow <= w_ovf_next;
      r_busy     <= |w_pend_next;
      if (w_sel) begin
        if (w_found) begin
          r_valid <= 1'b1;
          r_addr  <= w_win;
          if (RR_EN) r_last <= w_win;
        end else begin
          r_valid <= 1'b0;
        end
      end else if (w_accept) begin
        // Accepted while disabled: drop valid, no new pick until en returns.
        r_valid <= 1'b0;
      end
    end
  end

  assign valid    = r_valid;
  assign addr     = r_addr;
  assign grant    = r_grant;
  assign pending  = r_pending;
  assign overflow = r_overflow;
  assign busy     = r_busy;

endmodule

// File: tb/tb_wb_req_encoder.sv
module tb_wb_req_encoder;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [7:0] req;
  logic       ready;
  logic       ovf_clr;

  logic       valid,   fp_valid;
  logic [2:0] addr,    fp_addr;
  logic [7:0] grant,   fp_grant;
  logic [7:0] pending, fp_pending;
  logic [7:0] overflow, fp_overflow;
  logic       busy,    fp_busy;

  int n_chk;
  int n_fail;

  wb_req_encoder #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req), .ready(ready),
    .ovf_clr(ovf_clr), .valid(valid), .addr(addr), .grant(grant),
    .pending(pending), .overflow(overflow), .busy(busy)
  );

  wb_req_encoder #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req), .ready(ready),
    .ovf_clr(ovf_clr), .valid(fp_valid), .addr(fp_addr), .grant(fp_grant),
    .pending(fp_pending), .overflow(fp_overflow), .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (drive and sample point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req     = 8'h00;
    ready   = 1'b0;
    en      = 1'b1;
    ovf_clr = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 8'hFF;
    ready   = 1'b1;
    en      = 1'b1;
    ovf_clr = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({valid, addr, grant, pending, overflow, busy} !== {1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold: got v=%b a=%0d g=%h p=%h o=%h b=%b, want all zero",
               valid, addr, grant, pending, overflow, busy);
    end
    req = 8'h00;
    reset_n = 1'b1;
    tick();
    n_chk++;
    if ({valid, pending} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b p=%h, want v=0 p=00", valid, pending);
    end
  endtask

  task automatic test_single();
    apply_reset();
    ready = 1'b1;
    req   = 8'h20;
    tick();
    req = 8'h00;
    n_chk++;
    if ({valid, addr, pending, busy} !== {1'b1, 3'd5, 8'h20, 1'b1}) begin
      n_fail++;
      $display("FAIL single_present: got v=%b a=%0d p=%h b=%b, want v=1 a=5 p=20 b=1",
               valid, addr, pending, busy);
    end
    tick();
    n_chk++;
    if ({valid, grant, pending, busy} !== {1'b0, 8'h20, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL single_grant: got v=%b g=%h p=%h b=%b, want v=0 g=20 p=00 b=0",
               valid, grant, pending, busy);
    end
    tick();
    n_chk++;
    if (grant !== 8'h00) begin
      n_fail++;
      $display("FAIL single_grant_width: got g=%h, want 00", grant);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_p;
    logic [7:0] exp_g;
    apply_reset();
    ready = 1'b1;
    req   = 8'hFF;
    tick();
    req = 8'h00;
    n_chk++;
    if ({valid, addr, pending} !== {1'b1, 3'd0, 8'hFF}) begin
      n_fail++;
      $display("FAIL rr_first: got v=%b a=%0d p=%h, want v=1 a=0 p=ff", valid, addr, pending);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      exp_p = 8'hFF << i;
      exp_g = 8'h01 << (i - 1);
      n_chk++;
      if ({valid, addr, grant, pending} !== {1'b1, 3'(i), exp_g, exp_p}) begin
        n_fail++;
        $display("FAIL rr_seq%0d: got v=%b a=%0d g=%h p=%h, want v=1 a=%0d g=%h p=%h",
                 i, valid, addr, grant, pending, i, exp_g, exp_p);
      end
    end
    tick();
    n_chk++;
    if ({valid, grant, pending} !== {1'b0, 8'h80, 8'h00}) begin
      n_fail++;
      $display("FAIL rr_drain: got v=%b g=%h p=%h, want v=0 g=80 p=00", valid, grant, pending);
    end
    req = 8'h81;
    tick();
    req = 8'h00;
    n_chk++;
    if ({valid, addr} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL rr_wrap0: got v=%b a=%0d, want v=1 a=0", valid, addr);
    end
    tick();
    n_chk++;
    if ({valid, addr, grant} !== {1'b1, 3'd7, 8'h01}) begin
      n_fail++;
      $display("FAIL rr_wrap7: got v=%b a=%0d g=%h, want v=1 a=7 g=01", valid, addr, grant);
    end
    tick();
    n_chk++;
    if ({valid, grant} !== {1'b0, 8'h80}) begin
      n_fail++;
      $display("FAIL rr_wrap_end: got v=%b g=%h, want v=0 g=80", valid, grant);
    end
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    ready = 1'b1;
    req   = 8'h81;
    tick();
    n_chk++;
    if ({fp_valid, fp_addr, fp_pending} !== {1'b1, 3'd0, 8'h81}) begin
      n_fail++;
      $display("FAIL fp_first: got v=%b a=%0d p=%h, want v=1 a=0 p=81", fp_valid, fp_addr, fp_pending);
    end
    req = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if ({fp_valid, fp_addr, fp_grant, fp_pending, fp_overflow} !== {1'b1, 3'd0, 8'h01, 8'h81, 8'h00}) begin
        n_fail++;
        $display("FAIL fp_starve%0d: got v=%b a=%0d g=%h p=%h o=%h, want v=1 a=0 g=01 p=81 o=00",
                 i, fp_valid, fp_addr, fp_grant, fp_pending, fp_overflow);
      end
      if (i == 0) begin
        // Round-robin instance rotates to index 7 instead of repeating 0.
        n_chk++;
        if ({valid, addr} !== {1'b1, 3'd7}) begin
          n_fail++;
          $display("FAIL rr_vs_fp: got v=%b a=%0d, want v=1 a=7", valid, addr);
        end
      end
    end
    req = 8'h00;
    tick();
    n_chk++;
    if ({fp_valid, fp_addr, fp_grant} !== {1'b1, 3'd7, 8'h01}) begin
      n_fail++;
      $display("FAIL fp_release: got v=%b a=%0d g=%h, want v=1 a=7 g=01", fp_valid, fp_addr, fp_grant);
    end
    tick();
    n_chk++;
    if ({fp_valid, fp_grant, fp_pending} !== {1'b0, 8'h80, 8'h00}) begin
      n_fail++;
      $display("FAIL fp_drain: got v=%b g=%h p=%h, want v=0 g=80 p=00", fp_valid, fp_grant, fp_pending);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      req = (c == 1) ? 8'h10 : ((c == 2) ? 8'h01 : 8'h00);
      tick();
      n_chk++;
      if ({valid, addr, grant} !== {1'b1, 3'd4, 8'h00}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b a=%0d g=%h, want v=1 a=4 g=00", c, valid, addr, grant);
      end
    end
    req = 8'h00;
    n_chk++;
    if (pending !== 8'h11) begin
      n_fail++;
      $display("FAIL bp_pending: got p=%h, want 11", pending);
    end
    ready = 1'b1;
    tick();
    n_chk++;
    if ({valid, addr, grant, pending} !== {1'b1, 3'd0, 8'h10, 8'h01}) begin
      n_fail++;
      $display("FAIL bp_next: got v=%b a=%0d g=%h p=%h, want v=1 a=0 g=10 p=01",
               valid, addr, grant, pending);
    end
    tick();
    n_chk++;
    if ({valid, grant, pending} !== {1'b0, 8'h01, 8'h00}) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%b g=%h p=%h, want v=0 g=01 p=00", valid, grant, pending);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    ready = 1'b0;
    req   = 8'h08;
    tick();
    n_chk++;
    if ({valid, addr, overflow} !== {1'b1, 3'd3, 8'h00}) begin
      n_fail++;
      $display("FAIL ovf_first: got v=%b a=%0d o=%h, want v=1 a=3 o=00", valid, addr, overflow);
    end
    tick();
    req = 8'h00;
    tick();
    n_chk++;
    if (overflow !== 8'h08) begin
      n_fail++;
      $display("FAIL ovf_sticky: got o=%h, want 08", overflow);
    end
    ovf_clr = 1'b1;
    tick();
    n_chk++;
    if (overflow !== 8'h00) begin
      n_fail++;
      $display("FAIL ovf_clear: got o=%h, want 00", overflow);
    end
    req = 8'h08;
    tick();
    n_chk++;
    if (overflow !== 8'h08) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got o=%h, want 08", overflow);
    end
    // Clear while req[3] coincides with acceptance of addr 3: no new overflow.
    ready = 1'b1;
    tick();
    ovf_clr = 1'b0;
    req     = 8'h00;
    n_chk++;
    if ({valid, addr, grant, pending, overflow} !== {1'b1, 3'd3, 8'h08, 8'h08, 8'h00}) begin
      n_fail++;
      $display("FAIL ovf_same_cycle: got v=%b a=%0d g=%h p=%h o=%h, want v=1 a=3 g=08 p=08 o=00",
               valid, addr, grant, pending, overflow);
    end
    tick();
    n_chk++;
    if ({valid, grant, pending, overflow} !== {1'b0, 8'h08, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL ovf_drain: got v=%b g=%h p=%h o=%h, want v=0 g=08 p=00 o=00",
               valid, grant, pending, overflow);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    en    = 1'b0;
    ready = 1'b1;
    req   = 8'h04;
    tick();
    req = 8'h00;
    tick();
    n_chk++;
    if ({valid, pending, busy} !== {1'b0, 8'h04, 1'b1}) begin
      n_fail++;
      $display("FAIL en_off: got v=%b p=%h b=%b, want v=0 p=04 b=1", valid, pending, busy);
    end
    en = 1'b1;
    tick();
    n_chk++;
    if ({valid, addr} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL en_on: got v=%b a=%0d, want v=1 a=2", valid, addr);
    end
    tick();
    n_chk++;
    if ({valid, grant, pending} !== {1'b0, 8'h04, 8'h00}) begin
      n_fail++;
      $display("FAIL en_drain: got v=%b g=%h p=%h, want v=0 g=04 p=00", valid, grant, pending);
    end
    // Accept while disabled: valid drops even though a request remains.
    ready = 1'b0;
    req   = 8'h24;
    tick();
    req = 8'h00;
    n_chk++;
    if ({valid, addr, pending} !== {1'b1, 3'd5, 8'h24}) begin
      n_fail++;
      $display("FAIL en_pre: got v=%b a=%0d p=%h, want v=1 a=5 p=24", valid, addr, pending);
    end
    en    = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({valid, pending} !== {1'b0, 8'h04}) begin
      n_fail++;
      $display("FAIL en_accept_off: got v=%b p=%h, want v=0 p=04", valid, pending);
    end
    ready = 1'b0;
    en    = 1'b1;
    tick();
    n_chk++;
    if ({valid, addr} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL en_resume: got v=%b a=%0d, want v=1 a=2", valid, addr);
    end
  endtask

  task automatic test_async_reset();
    // Entered with valid=1 held by ready=0; reset mid-cycle.
    #3;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({valid, addr, grant, pending, overflow, busy} !== {1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b a=%0d g=%h p=%h o=%h b=%b, want all zero",
               valid, addr, grant, pending, overflow, busy);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_chk++;
    if ({valid, pending} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset_after: got v=%b p=%h, want v=0 p=00", valid, pending);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    en      = 1'b1;
    req     = 8'h00;
    ready   = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_overflow();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
